clk_divider_n: RTL

Parametrised successor to the fixed divide-by-3 clock reducer. Divides the system clock by a runtime-programmable integer N. Produces a divided square or pulse waveform plus a one-cycle `tick` enable for downstream slow logic, such as a multicycle MIPS stage or peripheral strobes. Uses posedge logic only, in a single clock domain. Divisor changes are glitch-free and always take effect on a period boundary.

---
 rtl/clkdiv_pkg.sv | 5 +
 rtl/clk_divider_n_if.sv | 15 +
 rtl/clkdiv_phase_ctr.sv | 55 +++++
 rtl/clk_divider_n.sv | 77 +++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock divider.
package clkdiv_pkg;
  localparam logic CLKDIV_SQUARE = 1'b0;
  localparam logic CLKDIV_PULSE  = 1'b1;
endpackage

// File: rtl/clk_divider_n_if.sv
// Divisor programming inputs and divided-clock outputs of clk_divider_n.
interface clk_divider_n_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] div_in;
  logic             mode_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] phase;
  logic             div_pending;

  modport master (output div_in, mode_in, div_load,
                  input  clk_out, tick, phase, div_pending);
  modport slave  (input  div_in, mode_in, div_load,
                  output clk_out, tick, phase, div_pending);
endinterface

// File: rtl/clkdiv_phase_ctr.sv
// Phase counter holding the active divisor/mode; a staged divisor is taken
// only at a period boundary, and next-state values are exported for decode.
module clkdiv_phase_ctr
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_div_i,
  input  logic             load_mode_i,
  output logic             boundary_o,
  output logic [WIDTH-1:0] phase_o,
  output logic [WIDTH-1:0] phase_d_o,
  output logic [WIDTH-1:0] div_d_o,
  output logic             mode_d_o
);
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             mode_q, mode_d;

  // A zero divisor means stopped: every edge is a boundary so a new load restarts at once.
  always_comb begin
    boundary_o = (div_q == '0) || (phase_q == div_q - WIDTH'(1));
    phase_d    = phase_q + WIDTH'(1);
    div_d      = div_q;
    mode_d     = mode_q;
    if (boundary_o) begin
      phase_d = '0;
      if (load_i) begin
        div_d  = load_div_i;
        mode_d = load_mode_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= WIDTH'(RESET_DIV - 1);
      div_q   <= WIDTH'(RESET_DIV);
      mode_q  <= CLKDIV_SQUARE;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
    end
  end

  assign phase_o   = phase_q;
  assign phase_d_o = phase_d;
  assign div_d_o   = div_d;
  assign mode_d_o  = mode_d;
endmodule

// File: rtl/clk_divider_n.sv
// Runtime-programmable integer clock divider: registered square/pulse output,
// one-cycle tick per period, glitch-free divisor changes on period boundaries.
module clk_divider_n
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic            clk,
  input  logic            reset,
  clk_divider_n_if.slave  bus
);
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             boundary;
  logic [WIDTH-1:0] phase_cur, phase_nxt, div_nxt;
  logic             mode_nxt;
  logic [WIDTH:0]   half_up;

  clkdiv_phase_ctr #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) u_ctr (
    .clk         (clk),
    .reset       (reset),
    .load_i      (pend_q),
    .load_div_i  (pend_div_q),
    .load_mode_i (pend_mode_q),
    .boundary_o  (boundary),
    .phase_o     (phase_cur),
    .phase_d_o   (phase_nxt),
    .div_d_o     (div_nxt),
    .mode_d_o    (mode_nxt)
  );

  // A load on a boundary edge re-arms staging after the old stage is consumed.
  always_comb begin
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    if (boundary) pend_d = 1'b0;
    if (bus.div_load) begin
      pend_d      = 1'b1;
      pend_div_d  = bus.div_in;
      pend_mode_d = bus.mode_in;
    end
  end

  // Decode from next-cycle phase/divisor so outputs are plain registers.
  always_comb begin
    half_up   = ({1'b0, div_nxt} + (WIDTH+1)'(1)) >> 1;
    tick_d    = (div_nxt != '0) && (phase_nxt == '0);
    clk_out_d = (mode_nxt == CLKDIV_PULSE) ? tick_d : ({1'b0, phase_nxt} < half_up);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_div_q  <= '0;
      pend_mode_q <= CLKDIV_SQUARE;
      pend_q      <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.tick        = tick_q;
  assign bus.phase       = phase_cur;
  assign bus.div_pending = pend_q;
endmodule
